// File: rtl/motor_channel_ctrl_pkg.sv
// Shared types for the motor channel controller: channel FSM states and
// quadrature step classification used by every quad_decoder instance.
package motor_channel_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_DRIVE
    } ch_state_e;

    typedef enum logic [1:0] {
        STEP_ZERO,
        STEP_PLUS,
        STEP_MINUS,
        STEP_ERR
    } quad_step_e;

    // Position of an {A,B} pair along the forward cycle 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic quad_step_e quad_step(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
        logic [1:0] delta;
        quad_step_e step;
        delta = gray_idx(cur_ab) - gray_idx(prev_ab);
        case (delta)
            2'd0:    step = STEP_ZERO;
            2'd1:    step = STEP_PLUS;
            2'd3:    step = STEP_MINUS;
            default: step = STEP_ERR;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/motor_channel_ctrl_quad_decoder.sv
// Quadrature decoder for one encoder: 2-flop synchronizer, optional glitch
// filter (ENC_FILTER_EN), wrapping position counter and sticky error flag.
module quad_decoder
    import motor_channel_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] position,
    output logic             enc_err
);

    logic [1:0] sync1, sync2;
    logic [1:0] prev_ab;
    logic [1:0] cur_ab;
    quad_step_e step;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

`ifdef ENC_FILTER_EN
    logic [1:0] hist1, hist2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1 <= '0;
            hist2 <= '0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end

    // prev_ab doubles as the filter's held level; a bit moves only when the
    // last three synced samples agree.
    // NOTE: the default assignment first keeps this block purely
    // combinational; without it a missed path would infer a latch.
    always_comb begin
        cur_ab = prev_ab;
        for (int b = 0; b < 2; b++) begin
            if (sync2[b] == hist1[b] && hist1[b] == hist2[b])
                cur_ab[b] = sync2[b];
        end
    end
`else
    assign cur_ab = sync2;
`endif

    assign step = quad_step(prev_ab, cur_ab);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_ab  <= '0;
            position <= '0;
            enc_err  <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            if (cnt_clr) begin
                position <= '0;
                enc_err  <= 1'b0;
            end else begin
                unique case (step)
                    STEP_ZERO:  position <= position;
                    STEP_PLUS:  position <= position + CNT_W'(1);
                    STEP_MINUS: position <= position - CNT_W'(1);
                    STEP_ERR:   enc_err  <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/motor_channel_ctrl.sv
// Multi-channel H-bridge PWM driver with dead-time FSM and quadrature position
// feedback. Define ENC_FILTER_EN to add a 3-sample glitch filter on encoders.
module motor_channel_ctrl
    import motor_channel_ctrl_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PWM_W  = 8,
    parameter int CNT_W  = 16,
    parameter int DT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pwm_en,
    input  logic [NUM_CH*PWM_W-1:0] duty,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [DT_W-1:0]         dead_time,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       cnt_clr,
    output logic [NUM_CH-1:0]       motor_pos,
    output logic [NUM_CH-1:0]       motor_neg,
    output logic [NUM_CH*CNT_W-1:0] position,
    output logic [NUM_CH-1:0]       enc_err
);

    // Counter stops one short of all-ones so a full-scale duty is 100% on.
    localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PWM_W-1:0] pwm_cnt, pwm_cnt_nxt;
    logic             wrap;

    assign wrap        = (pwm_cnt == PWM_LAST);
    assign pwm_cnt_nxt = wrap ? '0 : pwm_cnt + PWM_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pwm_cnt <= '0;
        else      pwm_cnt <= pwm_cnt_nxt;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e        state, state_nxt;
        logic [PWM_W-1:0] duty_sh, duty_sh_nxt;
        logic             dir_sh, dir_sh_nxt;
        logic [DT_W-1:0]  dt_cnt, dt_cnt_nxt;
        logic             dead_done;
        logic             raw_nxt;
        logic             pos_q, neg_q;

        assign duty_sh_nxt = wrap ? duty[i*PWM_W +: PWM_W] : duty_sh;
        assign dir_sh_nxt  = wrap ? dir[i] : dir_sh;
        // A zero dead_time still spends one cycle in DEAD.
        assign dead_done   = ({1'b0, dt_cnt} + (DT_W+1)'(1)) >= {1'b0, dead_time};

        always_comb begin
            state_nxt  = state;
            dt_cnt_nxt = dt_cnt;
            if (!pwm_en) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wrap) begin
                            state_nxt  = ST_DEAD;
                            dt_cnt_nxt = '0;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_done) state_nxt  = ST_DRIVE;
                        else           dt_cnt_nxt = dt_cnt + DT_W'(1);
                    end
                    ST_DRIVE: begin
                        if (wrap && dir[i] != dir_sh) begin
                            state_nxt  = ST_DEAD;
                            dt_cnt_nxt = '0;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        // Outputs are registered from next-cycle values so they line up with
        // the state, counter and shadow registers they are derived from.
        assign raw_nxt = (pwm_cnt_nxt < duty_sh_nxt);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= ST_IDLE;
                dt_cnt  <= '0;
                duty_sh <= '0;
                dir_sh  <= 1'b0;
                pos_q   <= 1'b0;
                neg_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                dt_cnt  <= dt_cnt_nxt;
                duty_sh <= duty_sh_nxt;
                dir_sh  <= dir_sh_nxt;
                pos_q   <= (state_nxt == ST_DRIVE) &&  dir_sh_nxt && raw_nxt;
                neg_q   <= (state_nxt == ST_DRIVE) && !dir_sh_nxt && raw_nxt;
            end
        end

        assign motor_pos[i] = pos_q;
        assign motor_neg[i] = neg_q;

        quad_decoder #(
            .CNT_W (CNT_W)
        ) u_quad (
            .clk      (clk),
            .rst      (rst),
            .enc_a    (enc_a[i]),
            .enc_b    (enc_b[i]),
            .cnt_clr  (cnt_clr[i]),
            .position (position[i*CNT_W +: CNT_W]),
            .enc_err  (enc_err[i])
        );
    end

endmodule

// File: tb/tb_motor_channel_ctrl.sv
// Self-checking bench for motor_channel_ctrl: table-driven encoder and PWM
// vectors through scoreboard queues, plus hand-written timing sequences.
module tb_motor_channel_ctrl;

    localparam int PERIOD = 255;
`ifdef ENC_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_en;
    logic [15:0] duty;
    logic [1:0]  dir;
    logic [3:0]  dead_time;
    logic [1:0]  enc_a, enc_b, cnt_clr;
    logic [1:0]  motor_pos, motor_neg;
    logic [31:0] position;
    logic [1:0]  enc_err;

    motor_channel_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_en    (pwm_en),
        .duty      (duty),
        .dir       (dir),
        .dead_time (dead_time),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .cnt_clr   (cnt_clr),
        .motor_pos (motor_pos),
        .motor_neg (motor_neg),
        .position  (position),
        .enc_err   (enc_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  ab;
        logic        clr;
        logic [15:0] pos;
        logic        err;
    } enc_vec_t;

    typedef struct {
        logic [7:0] d0;
        logic       r0;
        logic [7:0] d1;
        logic       r1;
        int         p0, n0, p1, n1;
    } pwm_vec_t;

    enc_vec_t enc_tbl[15];
    pwm_vec_t pwm_tbl[5];
    enc_vec_t enc_q[$];
    pwm_vec_t pwm_q[$];

    task automatic wait_rise(input int ch, input bit use_neg, output bit found);
        logic prev, cur;
        found = 1'b0;
        prev  = use_neg ? motor_neg[ch] : motor_pos[ch];
        for (int i = 0; i < 2 * PERIOD && !found; i++) begin
            @(negedge clk);
            cur = use_neg ? motor_neg[ch] : motor_pos[ch];
            if (cur && !prev) found = 1'b1;
            prev = cur;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        enc_vec_t ev;
        pwm_vec_t pv;
        bit       found;
        int       cp0, cn0, cp1, cn1, ov, mism, nz;
        int       c, per;

        // {ab, clr, expected position, expected err} on channel 0, from 00.
        enc_tbl[0]  = '{2'b10, 1'b0, 16'h0001, 1'b0};
        enc_tbl[1]  = '{2'b11, 1'b0, 16'h0002, 1'b0};
        enc_tbl[2]  = '{2'b01, 1'b0, 16'h0003, 1'b0};
        enc_tbl[3]  = '{2'b00, 1'b0, 16'h0004, 1'b0};
        enc_tbl[4]  = '{2'b01, 1'b0, 16'h0003, 1'b0};
        enc_tbl[5]  = '{2'b11, 1'b0, 16'h0002, 1'b0};
        enc_tbl[6]  = '{2'b10, 1'b0, 16'h0001, 1'b0};
        enc_tbl[7]  = '{2'b00, 1'b0, 16'h0000, 1'b0};
        enc_tbl[8]  = '{2'b01, 1'b0, 16'hFFFF, 1'b0};
        enc_tbl[9]  = '{2'b00, 1'b0, 16'h0000, 1'b0};
        enc_tbl[10] = '{2'b10, 1'b0, 16'h0001, 1'b0};
        enc_tbl[11] = '{2'b01, 1'b0, 16'h0001, 1'b1};
        enc_tbl[12] = '{2'b01, 1'b0, 16'h0001, 1'b1};
        enc_tbl[13] = '{2'b01, 1'b1, 16'h0000, 1'b0};
        enc_tbl[14] = '{2'b11, 1'b0, 16'hFFFF, 1'b0};

        // {duty0, dir0, duty1, dir1, high cycles per period: pos0, neg0, pos1, neg1}
        pwm_tbl[0] = '{8'd64,  1'b1, 8'd32,  1'b0, 64,  0,   0,   32};
        pwm_tbl[1] = '{8'd0,   1'b1, 8'd255, 1'b0, 0,   0,   0,   255};
        pwm_tbl[2] = '{8'd255, 1'b1, 8'd0,   1'b0, 255, 0,   0,   0};
        pwm_tbl[3] = '{8'd100, 1'b0, 8'd200, 1'b1, 0,   100, 200, 0};
        pwm_tbl[4] = '{8'd1,   1'b1, 8'd254, 1'b1, 1,   0,   254, 0};

        rst       = 1'b0;
        pwm_en    = 1'b0;
        duty      = '0;
        dir       = '0;
        dead_time = 4'd3;
        enc_a     = '0;
        enc_b     = '0;
        cnt_clr   = '0;

        repeat (3) @(negedge clk);
        check("rst_motor_pos", motor_pos, 0);
        check("rst_motor_neg", motor_neg, 0);
        check("rst_position", position, 0);
        check("rst_enc_err", enc_err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Encoder table through the scoreboard.
        for (int v = 0; v < 15; v++) begin
            enc_a[0] = enc_tbl[v].ab[1];
            enc_b[0] = enc_tbl[v].ab[0];
            enc_q.push_back(enc_tbl[v]);
            if (enc_tbl[v].clr) begin
                cnt_clr[0] = 1'b1;
                @(negedge clk);
                cnt_clr[0] = 1'b0;
            end
            repeat (LAT + 3) @(negedge clk);
            ev = enc_q.pop_front();
            check($sformatf("enc%0d_pos", v), position[15:0], ev.pos);
            check($sformatf("enc%0d_err", v), enc_err[0], ev.err);
        end

        // Exact latency: 11 -> 10 is a reverse step.
        enc_a[0] = 1'b1; enc_b[0] = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("lat_before", position[15:0], 16'hFFFF);
        @(negedge clk);
        check("lat_at", position[15:0], 16'hFFFE);
        repeat (3) @(negedge clk);

        // Clear lands on the same edge as a reverse step 10 -> 00.
        enc_a[0] = 1'b0; enc_b[0] = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        cnt_clr[0] = 1'b1;
        @(negedge clk);
        cnt_clr[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_step_pos", position[15:0], 16'h0000);

        // Clear lands on the same edge as an illegal 00 -> 11 jump.
        enc_a[0] = 1'b1; enc_b[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        cnt_clr[0] = 1'b1;
        @(negedge clk);
        cnt_clr[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_err_pos", position[15:0], 16'h0000);
        check("clr_err_flag", enc_err[0], 1'b0);

`ifdef ENC_FILTER_EN
        enc_a[0] = 1'b0;
        repeat (2) @(negedge clk);
        enc_a[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_pos", position[15:0], 16'h0000);
        check("glitch_err", enc_err[0], 1'b0);
`endif

        // Channel 1 is independent: 00 -> 01 is a reverse step.
        enc_b[1] = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("ch1_pos", position[31:16], 16'hFFFF);
        check("ch1_keeps_ch0", position[15:0], 16'h0000);

        // PWM table through the scoreboard.
        pwm_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            duty = {pwm_tbl[v].d1, pwm_tbl[v].d0};
            dir  = {pwm_tbl[v].r1, pwm_tbl[v].r0};
            pwm_q.push_back(pwm_tbl[v]);
            repeat (2 * PERIOD) @(negedge clk);
            cp0 = 0; cn0 = 0; cp1 = 0; cn1 = 0; ov = 0;
            repeat (PERIOD) begin
                @(negedge clk);
                cp0 += int'(motor_pos[0]);
                cn0 += int'(motor_neg[0]);
                cp1 += int'(motor_pos[1]);
                cn1 += int'(motor_neg[1]);
                if (|(motor_pos & motor_neg)) ov++;
            end
            pv = pwm_q.pop_front();
            check($sformatf("pwm%0d_pos0", v), cp0, pv.p0);
            check($sformatf("pwm%0d_neg0", v), cn0, pv.n0);
            check($sformatf("pwm%0d_pos1", v), cp1, pv.p1);
            check($sformatf("pwm%0d_neg1", v), cn1, pv.n1);
            check($sformatf("pwm%0d_overlap", v), ov, 0);
        end

        // Direction reversal mid-period with dead_time = 5.
        duty[7:0] = 8'd128;
        dir[0]    = 1'b1;
        dead_time = 4'd5;
        repeat (2 * PERIOD) @(negedge clk);
        wait_rise(0, 1'b0, found);
        check("rev_sync", found, 1'b1);
        c = 0;
        repeat (10) begin
            @(negedge clk);
            c++;
        end
        dir[0] = 1'b0;
        per  = 0;
        mism = 0;
        while (per < 2) begin
            if (per == 0) begin
                if (motor_pos[0] !== (c < 128) || motor_neg[0] !== 1'b0) mism++;
                if (c == 127) check("rev_old_dir_held", motor_pos[0], 1'b1);
            end else begin
                if (motor_pos[0] !== 1'b0 || motor_neg[0] !== (c >= 5 && c < 128)) mism++;
                if (c == 4) check("rev_dead_last", {motor_pos[0], motor_neg[0]}, 2'b00);
                if (c == 5) check("rev_drive_first", motor_neg[0], 1'b1);
            end
            @(negedge clk);
            c++;
            if (c == PERIOD) begin
                c = 0;
                per++;
            end
        end
        check("rev_mismatches", mism, 0);

        // Dropping pwm_en idles every channel on the next edge.
        wait_rise(0, 1'b1, found);
        check("en_sync", found, 1'b1);
        repeat (3) @(negedge clk);
        check("en_driving", motor_neg[0], 1'b1);
        pwm_en = 1'b0;
        @(negedge clk);
        check("en_off_pos", motor_pos, 2'b00);
        check("en_off_neg", motor_neg, 2'b00);

        // Asynchronous reset mid-drive, then the restart sequence.
        pwm_en = 1'b1;
        dir[0] = 1'b1;
        repeat (3 * PERIOD) @(negedge clk);
        wait_rise(0, 1'b0, found);
        check("rst_sync", found, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_pre_drive", motor_pos[0], 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_pos", motor_pos, 2'b00);
        check("rst_async_neg", motor_neg, 2'b00);
        check("rst_async_position", position, 0);
        @(negedge clk);
        rst = 1'b1;
        nz = 0;
        for (int k = 1; k < 260; k++) begin
            @(negedge clk);
            if (|(motor_pos | motor_neg)) nz++;
        end
        check("restart_quiet", nz, 0);
        @(negedge clk);
        check("restart_first_drive", motor_pos, 2'b11);
        check("restart_neg", motor_neg, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
